// File: rtl/credit_tx.sv
// Credit-flow transmitter: 2-entry input skid FIFO feeding one-cycle tx pulses,
// gated by a saturating credit counter replenished by the remote receiver.
module credit_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_CREDITS  = 8,
  parameter int INIT_CREDITS = MAX_CREDITS,
  localparam int CW          = $clog2(MAX_CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  credit_return,
  output logic [CW-1:0]         credits_avail,
  output logic                  overflow_err
);

  if (MAX_CREDITS < 1 || INIT_CREDITS > MAX_CREDITS || INIT_CREDITS < 0) begin : g_bad_params
    $error("credit_tx: require MAX_CREDITS >= 1 and 0 <= INIT_CREDITS <= MAX_CREDITS");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  occ, occ_nxt;
  logic [DATA_WIDTH-1:0] slot0, slot1;
  logic [DATA_WIDTH-1:0] slot0_nxt, slot1_nxt;
  logic [DATA_WIDTH-1:0] tx_data_nxt;
  logic [CW-1:0]         credits_nxt;
  logic                  in_ready_nxt;
  logic                  tx_valid_nxt;
  logic                  overflow_nxt;
  logic                  insert;
  logic                  send;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= EMPTY;
    end else begin
      occ <= occ_nxt;
    end
  end

  // slot0 is always the head; a pop shifts slot1 down into it.
  always_comb begin
    insert       = in_valid && in_ready;
    send         = (occ != EMPTY) && (credits_avail != '0);
    occ_nxt      = occ;
    slot0_nxt    = slot0;
    slot1_nxt    = slot1;
    tx_valid_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    credits_nxt  = credits_avail;
    overflow_nxt = overflow_err;

    if (send) begin
      tx_valid_nxt = 1'b1;
      tx_data_nxt  = slot0;
      slot0_nxt    = slot1;
    end

    unique case (occ)
      EMPTY: begin
        if (insert) begin
          slot0_nxt = in_data;
          occ_nxt   = ONE;
        end
      end
      ONE: begin
        if (insert && send) begin
          slot0_nxt = in_data;
        end else if (insert) begin
          slot1_nxt = in_data;
          occ_nxt   = TWO;
        end else if (send) begin
          occ_nxt   = EMPTY;
        end
      end
      TWO: begin
        if (send) begin
          occ_nxt = ONE;
        end
      end
      default: occ_nxt = EMPTY;
    endcase

    in_ready_nxt = (occ_nxt != TWO);

    // A return coinciding with a send cancels out, so only a lone return can overflow.
    if (credit_return && !send) begin
      if (credits_avail == CW'(MAX_CREDITS)) begin
        overflow_nxt = 1'b1;
      end else begin
        credits_nxt = credits_avail + CW'(1);
      end
    end else if (send && !credit_return) begin
      credits_nxt = credits_avail - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0         <= '0;
      slot1         <= '0;
      in_ready      <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      credits_avail <= CW'(INIT_CREDITS);
      overflow_err  <= 1'b0;
    end else begin
      slot0         <= slot0_nxt;
      slot1         <= slot1_nxt;
      in_ready      <= in_ready_nxt;
      tx_valid      <= tx_valid_nxt;
      tx_data       <= tx_data_nxt;
      credits_avail <= credits_nxt;
      overflow_err  <= overflow_nxt;
    end
  end

endmodule

// File: doc/credit_tx.md
Name: credit_tx

Overview:
- Transmitter end of a credit-flow link. Accepts a valid/ready stream from upstream and forwards it as one-cycle `tx_valid` pulses to a remote receiver. The receiver has no ready signal; it returns one credit per freed slot.
- Sits between a valid/ready producer and a long or registered path whose far end owns a fixed-depth receive buffer.
- The input side is decoupled by a 2-entry buffer so that `in_ready` is a registered signal and full throughput is sustained.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- MAX_CREDITS, 8, receive-buffer depth at the far end; ceiling for the credit counter; must be >= 1.
- INIT_CREDITS, MAX_CREDITS, credits held after reset; must be <= MAX_CREDITS (elaboration-time check).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_data  input  DATA_WIDTH  upstream payload.
- in_ready  output  1  registered; upstream beat is accepted when `in_valid && in_ready`.
- tx_valid  output  1  registered; one-cycle pulse per transmitted beat.
- tx_data  output  DATA_WIDTH  registered payload; qualified by `tx_valid`.
- credit_return  input  1  one-cycle pulse; the receiver has freed one slot.
- credits_avail  output  CW  current credit count, where CW = $clog2(MAX_CREDITS+1).
- overflow_err  output  1  sticky; a credit was returned while the counter was already at MAX_CREDITS.

Behaviour:
- Reset (asynchronous, takes effect immediately) sets:
  - buffer empty;
  - `in_ready` = 0, `tx_valid` = 0, `tx_data` = 0;
  - `credits_avail` = INIT_CREDITS;
  - `overflow_err` = 0.
- First clock edge after `rst` deasserts: `in_ready` becomes 1.
- Reset asserted mid-transfer: buffered beats are dropped, the counter reloads to INIT_CREDITS, and any `tx_valid` pulse is cut.
- Buffer:
  - 2-entry in-order FIFO with states EMPTY (0), ONE (1) and TWO (2).
  - `insert` = `in_valid && in_ready`.
  - `send` = (occupancy > 0) && (credits_avail > 0), evaluated on registered state.
  - Next occupancy = occupancy + `insert` - `send`. Insert and send in the same cycle leave occupancy unchanged.
- in_ready:
  - Registered: `in_ready` <= (next occupancy < 2).
  - Never depends combinationally on `in_valid` or `credit_return`.
  - An insert while occupancy is 2 cannot occur; the bench asserts this.
- Transmit:
  - On `send`, at the clock edge: `tx_data` <= head entry, `tx_valid` <= 1, head pops. Otherwise `tx_valid` <= 0 and `tx_data` holds its value.
  - Beats leave strictly in acceptance order.
  - Latency: a beat accepted in cycle N (sampled at the end of N) appears on `tx_valid` in cycle N+2 at the earliest.
  - Throughput: with credits continuously available, one beat per cycle, `in_ready` stays high.
- Credits:
  - Next count = count - `send` + `credit_return`.
  - `send` and `credit_return` in the same cycle leave the count unchanged.
  - A credit returned in cycle N is usable for a send decision in cycle N+1; there is no combinational credit bypass.
  - At count 0, nothing is sent even if the buffer is full.
  - `credit_return` while count == MAX_CREDITS and no send in that cycle: the count saturates at MAX_CREDITS and `overflow_err` <= 1, held until reset.
  - A credit returned at count MAX_CREDITS in the same cycle as a send is legal; the count is unchanged and no error is flagged.
- Invariant (bench check): beats sent minus credits returned is never greater than INIT_CREDITS.

Test Plan:
- Reset release, INIT_CREDITS=8, `in_valid` held high with data 0,1,2,…, `credit_return` = 0
  -> `in_ready`=1 one edge after release; `tx_valid` first high two cycles after the first accept; exactly 8 pulses carrying 0..7; `credits_avail` reaches 0; `in_ready` drops once 8 and 9 are buffered.
- From the previous end state, pulse `credit_return` once
  -> `credits_avail` shows 1 the next cycle; `tx_valid` pulses with data 8 the cycle after that; `credits_avail` returns to 0; `in_ready` rises again.
- Continuous stream with `credit_return` high every cycle after the first 8 sends
  -> one `tx_valid` per cycle with consecutive data; `credits_avail` constant; `in_ready` never drops.
- Idle at 8 credits, pulse `credit_return` once
  -> `credits_avail` stays 8; `overflow_err` = 1 and remains 1 until `rst`.
- Assert `rst` mid-stream with 2 beats buffered and 3 credits
  -> immediately `tx_valid`=0, `in_ready`=0, `credits_avail`=8, `overflow_err`=0; after release, the buffered beats are never transmitted.
